// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
// Fetches 32-bit instructions for the RV32I core from a byte-wide memory
// over a req/ack handshake. Bytes are assembled little-endian into a
// one-word buffer, so repeated fetches of the same PC cost no cycles.
// Misaligned PCs and memory timeouts raise a sticky fault that stalls
// the core until reset.
module inst_fetch_unit #(
    parameter int          ADDR_W      = 32,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic              sysclk,
    input  logic              sysreset,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              flush,
    output logic [31:0]       instruction,
    output logic              inst_valid,
    output logic              core_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              fetch_fault
);

    // Last wait count value at which a missing ack still counts as waiting;
    // one more cycle without ack means the memory has timed out.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // One-entry instruction buffer
    logic              buf_valid;
    logic [ADDR_W-1:0] tag;
    logic [31:0]       buf_data;

    // Fetch progress
    logic [ADDR_W-1:0] base;
    logic [1:0]        byte_cnt;
    logic [7:0]        wait_cnt;
    logic [23:0]       fill_data;
    logic              flush_pend;

    // Decoded events
    logic              tag_hit;
    logic              can_start;
    logic              start_fetch;
    logic              misaligned;
    logic              byte_ack;
    logic              word_done;
    logic              timed_out;

    // Decode buffer hit and the events that move the fetch along
    always_comb begin
        tag_hit     = buf_valid && (tag == inst_addr);
        can_start   = (state == IDLE) && !tag_hit && !fetch_fault;
        start_fetch = can_start && (inst_addr[1:0] == 2'b00);
        misaligned  = can_start && (inst_addr[1:0] != 2'b00);
        byte_ack    = (state == REQ) && mem_ack;
        word_done   = byte_ack && (byte_cnt == 2'd3);
        timed_out   = (state == REQ) && !mem_ack && (wait_cnt == WAIT_LAST);
    end

    // State register
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave IDLE only for an aligned miss, return on the
    // fourth byte or on a timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_fetch) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (word_done || timed_out) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs: memory request from the FSM, core-facing signals from the buffer
    always_comb begin
        mem_req     = (state == REQ);
        mem_addr    = '0;
        if (state == REQ) begin
            mem_addr = base + {{(ADDR_W-2){1'b0}}, byte_cnt};
        end
        inst_valid  = tag_hit && (state == IDLE) && !fetch_fault;
        core_stall  = !inst_valid;
        instruction = inst_valid ? buf_data : NOP_WORD;
    end

    // Fetch progress: base address, byte lane counter, wait counter,
    // partial word and the pending-flush flag
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            base       <= '0;
            byte_cnt   <= 2'd0;
            wait_cnt   <= 8'd0;
            fill_data  <= 24'd0;
            flush_pend <= 1'b0;
        end else if (start_fetch) begin
            base       <= inst_addr;
            byte_cnt   <= 2'd0;
            wait_cnt   <= 8'd0;
            flush_pend <= 1'b0;
        end else if (state == REQ) begin
            if (flush) begin
                flush_pend <= 1'b1;
            end
            if (mem_ack) begin
                wait_cnt <= 8'd0;
                case (byte_cnt)
                    2'd0:    fill_data[7:0]   <= mem_rdata;
                    2'd1:    fill_data[15:8]  <= mem_rdata;
                    2'd2:    fill_data[23:16] <= mem_rdata;
                    default: fill_data        <= fill_data;
                endcase
                if (byte_cnt != 2'd3) begin
                    byte_cnt <= byte_cnt + 2'd1;
                end else begin
                    byte_cnt   <= 2'd0;
                    flush_pend <= 1'b0;
                end
            end else if (timed_out) begin
                wait_cnt   <= 8'd0;
                byte_cnt   <= 2'd0;
                flush_pend <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Instruction buffer: load on the final byte, invalidate on flush or
    // timeout; a flush seen during the fetch keeps the new word invalid
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            buf_valid <= 1'b0;
            tag       <= '0;
            buf_data  <= NOP_WORD;
        end else if (word_done) begin
            tag       <= base;
            buf_data  <= {mem_rdata, fill_data};
            buf_valid <= !(flush_pend || flush);
        end else if (timed_out) begin
            buf_valid <= 1'b0;
        end else if ((state == IDLE) && flush) begin
            buf_valid <= 1'b0;
        end
    end

    // Sticky fault: misaligned PC on a miss or a memory timeout
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            fetch_fault <= 1'b0;
        end else if (misaligned || timed_out) begin
            fetch_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit
// Table of fetch vectors driven through a scoreboard, plus hand-written
// sequences for flush, address change, reset abort, stray ack, misaligned
// PC and memory timeout.
module tb_inst_fetch_unit;

    localparam int BOUND = 600;

    logic        sysclk;
    logic        sysreset;
    logic [31:0] inst_addr;
    logic        flush;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        core_stall;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        fetch_fault;

    logic [7:0]  mem [0:63];
    int          wait_states;
    int          wcnt;
    logic        ack_enable;
    logic        stray_ack;
    int          req_cycles;
    logic [31:0] addr_q[$];

    int          check_cnt;
    int          pass_cnt;

    typedef struct {
        string       name;
        logic [31:0] addr;
        int          waits;
        logic [31:0] word;
        int          lat;
        int          reqs;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[7];

    inst_fetch_unit #(
        .ADDR_W(32),
        .TIMEOUT_CYC(255),
        .NOP_WORD(32'h00000013)
    ) dut (
        .sysclk(sysclk),
        .sysreset(sysreset),
        .inst_addr(inst_addr),
        .flush(flush),
        .instruction(instruction),
        .inst_valid(inst_valid),
        .core_stall(core_stall),
        .mem_addr(mem_addr),
        .mem_req(mem_req),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .fetch_fault(fetch_fault)
    );

    // Free-running clock
    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Memory model: ack after wait_states idle cycles of a request
    always @(posedge sysclk) begin
        if (!mem_req || mem_ack) begin
            wcnt <= 0;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    assign mem_ack   = (mem_req && ack_enable && (wcnt >= wait_states)) || stray_ack;
    assign mem_rdata = mem[mem_addr[5:0]];

    // Monitor: count request cycles and log acknowledged addresses
    always @(negedge sysclk) begin
        if (mem_req) begin
            req_cycles++;
            if (mem_ack) begin
                addr_q.push_back(mem_addr);
            end
        end
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem[a[5:0] + 6'd3], mem[a[5:0] + 6'd2], mem[a[5:0] + 6'd1], mem[a[5:0]]};
    endfunction

    function automatic int miss_lat(input int w);
        return 1 + 4 * (w + 1);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic wait_valid(output int lat, output logic got);
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < BOUND; c++) begin
            @(negedge sysclk);
            #1;
            if (inst_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge sysclk);
            #1;
            lat++;
        end
    endtask

    task automatic check_fetch(input string name);
        int   lat;
        logic got;
        exp_t e;
        wait_valid(lat, got);
        check_output({name, "_valid"}, {31'd0, got}, 32'd1);
        if (sb_q.size() == 0) begin
            check_output({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_output({name, "_word"}, instruction, e.word);
            check_output({name, "_lat"}, lat, e.lat);
            check_output({name, "_reqs"}, req_cycles, e.reqs);
            check_output({name, "_stall"}, {31'd0, core_stall}, 32'd0);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(posedge sysclk);
        #1;
        sysreset    = 1'b1;
        wait_states = v.waits;
        inst_addr   = v.addr;
        req_cycles  = 0;
        addr_q.delete();
        sb_q.push_back('{v.word, v.lat, v.reqs});
        check_fetch(v.name);
    endtask

    task automatic do_reset;
        @(posedge sysclk);
        #1;
        sysreset    = 1'b0;
        flush       = 1'b0;
        stray_ack   = 1'b0;
        ack_enable  = 1'b1;
        wait_states = 0;
        inst_addr   = 32'd0;
        repeat (2) @(posedge sysclk);
        #1;
    endtask

    task automatic wait_mem_addr(input logic [31:0] a, input string name);
        logic found;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge sysclk);
            #1;
            if (mem_req && (mem_addr == a)) begin
                found = 1'b1;
                break;
            end
        end
        check_output(name, {31'd0, found}, 32'd1);
    endtask

    initial begin
        int   drops;
        logic hit_fault;

        check_cnt   = 0;
        pass_cnt    = 0;
        wcnt        = 0;
        req_cycles  = 0;
        flush       = 1'b0;
        stray_ack   = 1'b0;
        ack_enable  = 1'b1;
        wait_states = 0;
        inst_addr   = 32'd0;
        sysreset    = 1'b1;

        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'((i * 37) + 11);
        end
        mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'hA0; mem[3] = 8'h00;
        mem[4] = 8'hB3; mem[5] = 8'h81; mem[6] = 8'h20; mem[7] = 8'h00;

        vecs[0] = '{"miss0",  32'h0,  0, 32'h00A00093, 5,           4};
        vecs[1] = '{"hit0",   32'h0,  0, 32'h00A00093, 0,           0};
        vecs[2] = '{"miss4",  32'h4,  2, 32'h002081B3, 13,          12};
        vecs[3] = '{"hit4",   32'h4,  2, 32'h002081B3, 0,           0};
        vecs[4] = '{"miss8",  32'h8,  1, word_at(32'h8), miss_lat(1), 8};
        vecs[5] = '{"back0",  32'h0,  0, 32'h00A00093, miss_lat(0), 4};
        vecs[6] = '{"miss3c", 32'h3C, 3, word_at(32'h3C), miss_lat(3), 16};

        #2 sysreset = 1'b0;
        #1;
        check_output("rst_valid", {31'd0, inst_valid}, 32'd0);
        check_output("rst_stall", {31'd0, core_stall}, 32'd1);
        check_output("rst_instr", instruction, 32'h00000013);
        check_output("rst_req", {31'd0, mem_req}, 32'd0);
        check_output("rst_addr", mem_addr, 32'd0);
        check_output("rst_fault", {31'd0, fetch_fault}, 32'd0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i]);
            if (i == 0) begin
                check_output("fill0_naddr", addr_q.size(), 32'd4);
                for (int k = 0; k < 4; k++) begin
                    if (k < addr_q.size()) begin
                        check_output("fill0_addr", addr_q[k], k);
                    end
                end
                req_cycles = 0;
                drops      = 0;
                repeat (10) begin
                    @(negedge sysclk);
                    #1;
                    if (!inst_valid) drops++;
                end
                check_output("hold0_reqs", req_cycles, 32'd0);
                check_output("hold0_drops", drops, 32'd0);
            end
        end

        // Flush during the second byte: word completes invalid, then refetch
        @(posedge sysclk);
        #1;
        wait_states = 0;
        inst_addr   = 32'h0;
        req_cycles  = 0;
        wait_mem_addr(32'h1, "flush_mid_sync");
        flush = 1'b1;
        @(posedge sysclk);
        #1;
        flush = 1'b0;
        sb_q.push_back('{32'h00A00093, 7, 8});
        check_fetch("flush_mid");

        // Flush on the completing edge wins over the completing word
        @(posedge sysclk);
        #1;
        inst_addr  = 32'h4;
        req_cycles = 0;
        wait_mem_addr(32'h7, "flush_end_sync");
        flush = 1'b1;
        @(posedge sysclk);
        #1;
        flush = 1'b0;
        sb_q.push_back('{32'h002081B3, 5, 8});
        check_fetch("flush_end");

        // Flush during a hit invalidates the buffer at the next edge
        @(posedge sysclk);
        #1;
        flush = 1'b1;
        @(negedge sysclk);
        #1;
        check_output("flush_idle_still", {31'd0, inst_valid}, 32'd1);
        @(posedge sysclk);
        #1;
        flush      = 1'b0;
        req_cycles = 0;
        sb_q.push_back('{32'h002081B3, 5, 4});
        check_fetch("flush_idle");

        // PC change mid-fetch: old base completes, then the new PC is fetched
        @(posedge sysclk);
        #1;
        wait_states = 1;
        inst_addr   = 32'h8;
        req_cycles  = 0;
        repeat (3) @(posedge sysclk);
        #1;
        inst_addr = 32'h4;
        sb_q.push_back('{32'h002081B3, 15, 16});
        check_fetch("pc_change");

        // Reset mid-fetch aborts at once and keeps no partial word
        @(posedge sysclk);
        #1;
        wait_states = 2;
        inst_addr   = 32'h8;
        repeat (4) @(posedge sysclk);
        @(negedge sysclk);
        #1;
        sysreset = 1'b0;
        #1;
        check_output("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check_output("rst_mid_stall", {31'd0, core_stall}, 32'd1);
        check_output("rst_mid_instr", instruction, 32'h00000013);
        repeat (2) @(posedge sysclk);
        apply_stimulus('{"after_rst", 32'h8, 0, word_at(32'h8), 5, 4});

        // Ack while no request is outstanding must be ignored
        @(posedge sysclk);
        #1;
        stray_ack  = 1'b1;
        req_cycles = 0;
        repeat (3) @(negedge sysclk);
        #1;
        check_output("stray_valid", {31'd0, inst_valid}, 32'd1);
        check_output("stray_instr", instruction, word_at(32'h8));
        check_output("stray_reqs", req_cycles, 32'd0);
        stray_ack = 1'b0;

        // Misaligned PC raises a sticky fault without any request
        do_reset();
        @(posedge sysclk);
        #1;
        sysreset   = 1'b1;
        inst_addr  = 32'h6;
        req_cycles = 0;
        @(negedge sysclk);
        #1;
        check_output("misal_fault_c0", {31'd0, fetch_fault}, 32'd0);
        @(negedge sysclk);
        #1;
        check_output("misal_fault_c1", {31'd0, fetch_fault}, 32'd1);
        repeat (10) @(negedge sysclk);
        #1;
        inst_addr = 32'h0;
        repeat (10) @(negedge sysclk);
        #1;
        check_output("misal_reqs", req_cycles, 32'd0);
        check_output("misal_instr", instruction, 32'h00000013);
        check_output("misal_stall", {31'd0, core_stall}, 32'd1);
        check_output("misal_sticky", {31'd0, fetch_fault}, 32'd1);

        // Memory never acks: exactly TIMEOUT_CYC request cycles, then fault
        do_reset();
        ack_enable = 1'b0;
        @(posedge sysclk);
        #1;
        sysreset   = 1'b1;
        inst_addr  = 32'h0;
        req_cycles = 0;
        hit_fault  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge sysclk);
            #1;
            if (fetch_fault) begin
                hit_fault = 1'b1;
                break;
            end
        end
        check_output("tmo_fault", {31'd0, hit_fault}, 32'd1);
        check_output("tmo_reqs", req_cycles, 32'd255);
        check_output("tmo_req_low", {31'd0, mem_req}, 32'd0);
        ack_enable = 1'b1;
        req_cycles = 0;
        repeat (5) @(negedge sysclk);
        #1;
        check_output("tmo_no_refetch", req_cycles, 32'd0);
        check_output("tmo_stall", {31'd0, core_stall}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
